// File: rtl/six_bit_sign_mag_decoder.sv
// rtl/six_bit_sign_mag_decoder.sv - bit-serial two's-complement to sign-magnitude converter
// One bit per cycle, LSB first; result held in DONE until the consumer accepts it.
module six_bit_sign_mag_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sign,
  output logic [5:0] out_mag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q;
  logic       sign_q;
  logic       seen_one_q;
  logic [5:0] data_sr_q;
  logic [5:0] mag_sr_q;
  logic [2:0] bit_cnt_q;
  logic       in_ready_q;
  logic       out_valid_q;
  logic       out_sign_q;
  logic [5:0] out_mag_q;

  logic       cur_bit;
  logic       out_bit;
  logic [5:0] mag_sr_d;

  // Negate by copying up to and including the first 1, then inverting the rest.
  always_comb begin
    cur_bit  = data_sr_q[0];
    out_bit  = (sign_q && seen_one_q) ? ~cur_bit : cur_bit;
    mag_sr_d = {out_bit, mag_sr_q[5:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      seen_one_q  <= 1'b0;
      data_sr_q   <= 6'd0;
      mag_sr_q    <= 6'd0;
      bit_cnt_q   <= 3'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_mag_q   <= 6'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q     <= in_data[5];
            data_sr_q  <= in_data;
            seen_one_q <= 1'b0;
            mag_sr_q   <= 6'd0;
            bit_cnt_q  <= 3'd0;
            in_ready_q <= 1'b0;
            state_q    <= CONV;
          end
        end
        CONV: begin
          seen_one_q <= seen_one_q | cur_bit;
          data_sr_q  <= {1'b0, data_sr_q[5:1]};
          mag_sr_q   <= mag_sr_d;
          bit_cnt_q  <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd5) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_sign_q  <= sign_q;
            out_mag_q   <= mag_sr_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sign  = out_sign_q;
  assign out_mag   = out_mag_q;

endmodule

// File: tb/tb_six_bit_sign_mag_decoder.sv
// tb/tb_six_bit_sign_mag_decoder.sv - self-checking bench for six_bit_sign_mag_decoder
module tb_six_bit_sign_mag_decoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sign;
  logic [5:0] out_mag;

  int checks;
  int errors;

  six_bit_sign_mag_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mag   (out_mag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] data;
    logic       exp_sign;
    logic [5:0] exp_mag;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: value as a signed integer, magnitude by plain negation.
  function automatic void ref_model(input logic [5:0] d, output logic s, output int m);
    int v;
    v = (d >= 6'd32) ? int'(d) - 64 : int'(d);
    s = (v < 0);
    m = (v < 0) ? -v : v;
  endfunction

  // Presents one operand, returns the latency (edges after accept) and the result.
  task automatic do_op(input logic [5:0] d, output int lat, output logic s, output logic [5:0] m);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) chk("wait_in_ready", 0, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    s = out_sign;
    m = out_mag;
  endtask

  task automatic finish_handshake(input string name);
    @(posedge clk); #1;
    chk({name, "_valid_drop"}, out_valid, 0);
    chk({name, "_ready_rise"}, in_ready, 1);
  endtask

  initial begin
    vec_t       vecs[5];
    int         lat;
    logic       s;
    logic [5:0] m;
    logic       es;
    int         em;
    logic [5:0] codes[64];
    logic [5:0] tmp;
    int         j;
    int         bad;
    logic       s0;
    logic [5:0] m0;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 6'd0;
    out_ready = 1'b1;

    vecs[0] = '{6'b101011, 1'b1, 6'd21};
    vecs[1] = '{6'b100000, 1'b1, 6'd32};
    vecs[2] = '{6'b111111, 1'b1, 6'd1};
    vecs[3] = '{6'b000000, 1'b0, 6'd0};
    vecs[4] = '{6'b011111, 1'b0, 6'd31};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sign", out_sign, 0);
    chk("rst_out_mag", out_mag, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      do_op(vecs[i].data, lat, s, m);
      chk($sformatf("vec%0d_latency", i), lat, 6);
      chk($sformatf("vec%0d_sign", i), s, vecs[i].exp_sign);
      chk($sformatf("vec%0d_mag", i), m, vecs[i].exp_mag);
      finish_handshake($sformatf("vec%0d", i));
    end

    // in_valid held high with changing data while converting
    in_valid = 1'b1;
    in_data  = 6'b110110;
    @(posedge clk); #1;
    bad = 0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (in_ready) bad++;
      in_data = 6'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("hold_in_ready_low", bad, 0);
    chk("hold_latency", lat, 6);
    chk("hold_sign", out_sign, 1);
    chk("hold_mag", out_mag, 10);
    finish_handshake("hold");

    // backpressure in DONE
    out_ready = 1'b0;
    do_op(6'b101000, lat, s0, m0);
    chk("bp_latency", lat, 6);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || out_sign != s0 || out_mag != m0) bad++;
    end
    chk("bp_stable", bad, 0);
    chk("bp_sign", s0, 1);
    chk("bp_mag", m0, 24);
    out_ready = 1'b1;
    finish_handshake("bp");

    // reset mid-conversion
    in_valid = 1'b1;
    in_data  = 6'b100111;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_sign", out_sign, 0);
    chk("midrst_out_mag", out_mag, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(6'b111011, lat, s, m);
    chk("post_rst_latency", lat, 6);
    chk("post_rst_sign", s, 1);
    chk("post_rst_mag", m, 5);
    finish_handshake("post_rst");

    // all 64 codes in random order against the reference model
    for (int i = 0; i < 64; i++) codes[i] = 6'(i);
    for (int i = 63; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = codes[i]; codes[i] = codes[j]; codes[j] = tmp;
    end
    for (int i = 0; i < 64; i++) begin
      ref_model(codes[i], es, em);
      do_op(codes[i], lat, s, m);
      chk($sformatf("sweep_%0d_latency", codes[i]), lat, 6);
      chk($sformatf("sweep_%0d_sign", codes[i]), s, es);
      chk($sformatf("sweep_%0d_mag", codes[i]), m, em);
      @(posedge clk); #1;
      chk($sformatf("sweep_%0d_drop", codes[i]), out_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
